// File: rtl/sample_frame_router_if.sv
// Sample path bus between the synthesis engine, the router and the codec/display side.
interface sample_frame_router_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CH       = 2,
  parameter int DEPTH        = 8,
  parameter int CODEC_WIDTH  = 24
);
  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample_in;
  logic                           sample_valid;
  logic                           ready;
  logic                           new_frame;
  logic [1:0]                     mode;
  logic [2:0]                     atten;
  logic [CODEC_WIDTH-1:0]         hphone_l;
  logic [CODEC_WIDTH-1:0]         hphone_r;
  logic [SAMPLE_WIDTH-1:0]        disp_sample;
  logic                           disp_valid;
  logic [$clog2(DEPTH):0]         level;
  logic [7:0]                     underflow_cnt;
  logic [7:0]                     overflow_cnt;

  // Producer / codec side (drives frames and pop requests)
  modport master (
    output sample_in, sample_valid, new_frame, mode, atten,
    input  ready, hphone_l, hphone_r, disp_sample, disp_valid, level,
           underflow_cnt, overflow_cnt
  );

  // Router side
  modport slave (
    input  sample_in, sample_valid, new_frame, mode, atten,
    output ready, hphone_l, hphone_r, disp_sample, disp_valid, level,
           underflow_cnt, overflow_cnt
  );
endinterface

// File: rtl/sample_frame_router.sv
// Frame FIFO between synth engine and codec: routes each popped frame to
// L/R codec words (mono/stereo/mix/mute + attenuation) and a display tap.
module sample_frame_router #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_CH       = 2,
  parameter int DEPTH        = 8,
  parameter int CODEC_WIDTH  = 24
) (
  input logic                clk_100,
  input logic                reset,
  sample_frame_router_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(NUM_CH);
  localparam int SW  = SAMPLE_WIDTH + CW;
  localparam int CH1 = (NUM_CH > 1) ? 1 : 0;  // stereo falls back to ch0 on mono frames

  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl;
  logic          full, empty, push, pop;

  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] head;
  logic signed [SAMPLE_WIDTH-1:0] ch0, ch1, ch_s, avg, rt_l, rt_r, att_l, att_r;
  logic signed [SW-1:0]           sum, avg_full;
  logic [CODEC_WIDTH-1:0]         word_l, word_r;

  assign full  = (lvl == (AW+1)'(DEPTH));
  assign empty = (lvl == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign bus.ready = !full || bus.new_frame;
  assign push  = bus.sample_valid && bus.ready;
  assign pop   = bus.new_frame && !empty;
  assign bus.level = lvl;

  assign head = mem[rd_ptr];
  assign ch0  = head[0];
  assign ch1  = head[CH1];

  // Channel average: widen so the sum cannot overflow, floor-shift back down.
  always_comb begin
    sum  = '0;
    ch_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_s = head[k];
      sum  = sum + SW'(ch_s);
    end
    avg_full = sum >>> CW;
    avg      = avg_full[SAMPLE_WIDTH-1:0];
  end

  // Channel routing, attenuation and left-justified codec packing.
  always_comb begin
    rt_l = '0;
    rt_r = '0;
    case (bus.mode)
      2'd0:    begin rt_l = ch0; rt_r = ch0; end
      2'd1:    begin rt_l = ch0; rt_r = ch1; end
      2'd2:    begin rt_l = avg; rt_r = avg; end
      default: begin rt_l = '0;  rt_r = '0;  end
    endcase
    att_l  = rt_l >>> bus.atten;
    att_r  = rt_r >>> bus.atten;
    word_l = '0;
    word_r = '0;
    word_l[CODEC_WIDTH-1 -: SAMPLE_WIDTH] = att_l;
    word_r[CODEC_WIDTH-1 -: SAMPLE_WIDTH] = att_r;
  end

  // Frame storage; contents need no reset since the pointers/level discard them.
  always_ff @(posedge clk_100) begin
    if (push) mem[wr_ptr] <= bus.sample_in;
  end

  // Pointers, level, registered outputs and saturating event counters.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      lvl               <= '0;
      bus.hphone_l      <= '0;
      bus.hphone_r      <= '0;
      bus.disp_sample   <= '0;
      bus.disp_valid    <= 1'b0;
      bus.underflow_cnt <= '0;
      bus.overflow_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        bus.hphone_l    <= word_l;
        bus.hphone_r    <= word_r;
        bus.disp_sample <= avg;
      end
      bus.disp_valid <= pop;
      case ({push, pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
      if (bus.new_frame && empty && bus.underflow_cnt != 8'hFF)
        bus.underflow_cnt <= bus.underflow_cnt + 1'b1;
      if (bus.sample_valid && !bus.ready && bus.overflow_cnt != 8'hFF)
        bus.overflow_cnt <= bus.overflow_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_frame_router.sv
// Scoreboard bench for sample_frame_router: a frame-queue model predicts
// every pop; directed checks pin the documented example values.
module tb_sample_frame_router;
  localparam int SW = 16, NC = 2, DP = 8, CWD = 24;

  logic clk_100 = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_100 = ~clk_100;

  sample_frame_router_if #(.SAMPLE_WIDTH(SW), .NUM_CH(NC), .DEPTH(DP), .CODEC_WIDTH(CWD)) bus();

  sample_frame_router #(.SAMPLE_WIDTH(SW), .NUM_CH(NC), .DEPTH(DP), .CODEC_WIDTH(CWD)) dut (
    .clk_100(clk_100),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  int          n_chk = 0, n_fail = 0;
  int          m_unf = 0, m_ovf = 0;
  logic [23:0] last_l = '0, last_r = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // floor(v / 2^a), written as division so it is independent of shift semantics
  function automatic int fdiv(input int v, input int a);
    int p, q;
    p = 1 << a;
    q = v / p;
    if (v < 0 && q * p != v) q = q - 1;
    return q;
  endfunction

  function automatic logic [23:0] cw(input int v);
    logic [15:0] s;
    s = v[15:0];
    return {s, 8'h00};
  endfunction

  function automatic exp_t model(input logic [31:0] f, input logic [1:0] md, input logic [2:0] at);
    int c0, c1, avg, l, r;
    exp_t e;
    c0  = int'($signed(f[15:0]));
    c1  = int'($signed(f[31:16]));
    avg = fdiv(c0 + c1, 1);
    case (md)
      2'd0:    begin l = c0;  r = c0;  end
      2'd1:    begin l = c0;  r = c1;  end
      2'd2:    begin l = avg; r = avg; end
      default: begin l = 0;   r = 0;   end
    endcase
    e.l = cw(fdiv(l, int'(at)));
    e.r = cw(fdiv(r, int'(at)));
    e.d = avg[15:0];
    return e;
  endfunction

  // One clock of stimulus; model predicts ready/level/counters/outputs.
  task automatic tick(input logic sv, input logic [31:0] f, input logic nf);
    logic exp_rdy, push, pop;
    exp_t e;
    bus.sample_valid = sv;
    bus.sample_in    = f;
    bus.new_frame    = nf;
    #1;
    exp_rdy = (model_q.size() < DP) || nf;
    chk("ready", 32'(bus.ready), 32'(exp_rdy));
    push = sv && exp_rdy;
    pop  = nf && (model_q.size() > 0);
    if (pop) exp_q.push_back(model(model_q.pop_front(), bus.mode, bus.atten));
    if (nf && !pop && m_unf < 255) m_unf++;
    if (sv && !exp_rdy && m_ovf < 255) m_ovf++;
    if (push) model_q.push_back(f);
    @(posedge clk_100);
    #1;
    bus.sample_valid = 1'b0;
    bus.new_frame    = 1'b0;
    chk("level", 32'(bus.level), model_q.size());
    chk("underflow_cnt", 32'(bus.underflow_cnt), m_unf);
    chk("overflow_cnt", 32'(bus.overflow_cnt), m_ovf);
    chk("disp_valid", 32'(bus.disp_valid), 32'(pop));
    if (pop) begin
      e = exp_q.pop_front();
      chk("hphone_l", 32'(bus.hphone_l), 32'(e.l));
      chk("hphone_r", 32'(bus.hphone_r), 32'(e.r));
      chk("disp_sample", 32'(bus.disp_sample), 32'(e.d));
      last_l = e.l;
      last_r = e.r;
    end else begin
      chk("hold_l", 32'(bus.hphone_l), 32'(last_l));
      chk("hold_r", 32'(bus.hphone_r), 32'(last_r));
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.new_frame    = 1'b0;
    @(posedge clk_100);
    #1;
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_unf  = 0;
    m_ovf  = 0;
    last_l = '0;
    last_r = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_l"}, 32'(bus.hphone_l), 0);
    chk({tag, "_r"}, 32'(bus.hphone_r), 0);
    chk({tag, "_disp"}, 32'(bus.disp_sample), 0);
    chk({tag, "_dv"}, 32'(bus.disp_valid), 0);
    chk({tag, "_unf"}, 32'(bus.underflow_cnt), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow_cnt), 0);
    chk({tag, "_ready"}, 32'(bus.ready), 1);
  endtask

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.new_frame    = 1'b0;
    bus.mode         = 2'd1;
    bus.atten        = 3'd0;
    @(posedge clk_100);
    do_reset();
    chk_reset_state("rst");

    // stereo routing of a single frame
    tick(1'b1, {16'hF000, 16'h1000}, 1'b0);
    chk("tp1_level_up", 32'(bus.level), 1);
    tick(1'b0, '0, 1'b1);
    chk("tp1_l", 32'(bus.hphone_l), 32'h100000);
    chk("tp1_r", 32'(bus.hphone_r), 32'hF00000);
    chk("tp1_disp", 32'(bus.disp_sample), 32'h0000);
    chk("tp1_level_dn", 32'(bus.level), 0);

    // mix floor behaviour and attenuated mono
    bus.mode = 2'd2;
    tick(1'b1, {16'h0000, 16'h0003}, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("mix_pos", 32'(bus.hphone_l), 32'h000100);
    tick(1'b1, {16'h0000, 16'hFFFF}, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("mix_neg", 32'(bus.hphone_r), 32'hFFFF00);
    bus.mode  = 2'd0;
    bus.atten = 3'd2;
    tick(1'b1, {16'h0000, 16'h8000}, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("mono_atten", 32'(bus.hphone_l), 32'hE00000);
    bus.atten = 3'd0;

    // fill, overflow, simultaneous push/pop at full, ordered drain
    bus.mode = 2'd1;
    for (int i = 0; i < DP; i++) tick(1'b1, $urandom, 1'b0);
    tick(1'b1, $urandom, 1'b0);
    chk("ovf_one", 32'(bus.overflow_cnt), 1);
    tick(1'b1, $urandom, 1'b1);
    chk("full_pushpop_level", 32'(bus.level), DP);
    for (int i = 0; i < DP; i++) tick(1'b0, '0, 1'b1);

    // underflow holds the last word and saturates
    bus.mode = 2'd0;
    tick(1'b1, {16'h0000, 16'h1234}, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("unf_hold", 32'(bus.hphone_l), 32'h123400);
    chk("unf_one", 32'(bus.underflow_cnt), 1);
    for (int i = 0; i < 299; i++) tick(1'b0, '0, 1'b1);
    chk("unf_sat", 32'(bus.underflow_cnt), 255);

    // reset mid-stream discards frames
    for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0);
    do_reset();
    chk_reset_state("mid_rst");
    tick(1'b0, '0, 1'b1);
    chk("post_rst_unf", 32'(bus.underflow_cnt), 1);

    // pointer wrap with concurrent push/pop
    bus.mode = 2'd1;
    tick(1'b1, $urandom, 1'b0);
    for (int i = 0; i < DP + 3; i++) tick(1'b1, $urandom, 1'b1);
    tick(1'b0, '0, 1'b1);

    // mute keeps the display tap alive
    bus.mode = 2'd3;
    tick(1'b1, {16'h0200, 16'h0400}, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("mute_l", 32'(bus.hphone_l), 0);
    chk("mute_disp", 32'(bus.disp_sample), 32'h0300);

    // random traffic with random routing
    for (int i = 0; i < 60; i++) begin
      bus.mode  = 2'($urandom_range(0, 3));
      bus.atten = 3'($urandom_range(0, 7));
      tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_frame_router.md
# sample_frame_router

Parametrised sample path between the music player and the ADAU1761 codec and wave display. It accepts multi-channel sample frames from the synthesis engine and buffers them in a frame FIFO. On each codec `new_frame` request it pops one frame, routes it to the left/right headphone words (mono, stereo or mix mode, with attenuation) and emits a registered display tap. It replaces direct sample wiring and adds buffering, channel routing, and underflow/overflow accounting.

## Interface
- `SAMPLE_WIDTH`, 16, signed sample width per channel.
- `NUM_CH`, 2, channels per frame; power of two, 1..8.
- `DEPTH`, 8, FIFO depth in frames; power of two, ≥2.
- `CODEC_WIDTH`, 24, codec word width; must be ≥ SAMPLE_WIDTH.
- `clk_100`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_in`  in  NUM_CH*SAMPLE_WIDTH  frame; channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- `sample_valid`  in  1  push strobe for `sample_in`.
- `ready`  out  1  high when a push this cycle will be accepted.
- `new_frame`  in  1  codec request pulse; pops one frame.
- `mode`  in  2  routing: 0 mono (ch0 to L and R), 1 stereo (ch0 to L, ch1 to R; ch0 to both if NUM_CH=1), 2 mix (channel average to L and R), 3 mute (zeros).
- `atten`  in  3  arithmetic right shift applied to routed samples.
- `hphone_l`, `hphone_r`  out  CODEC_WIDTH  codec words: sample left-justified, low bits zero.
- `disp_sample`  out  SAMPLE_WIDTH  channel average of the last popped frame, pre-attenuation, pre-mute.
- `disp_valid`  out  1  one-cycle pulse when `disp_sample` updates.
- `level`  out  $clog2(DEPTH)+1  frames currently stored.
- `underflow_cnt`, `overflow_cnt`  out  8  saturating event counters.

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a level counter. Full when level==DEPTH; empty when level==0.
- `ready` = !full || new_frame. A pop in the same cycle frees a slot.
- Push: on `sample_valid && ready`, write the frame and advance the write pointer.
- Overflow: on `sample_valid && !ready`, drop the frame and increment `overflow_cnt`. The counter saturates at 255.
- Pop: on `new_frame && !empty`, read the head frame, advance the read pointer, and register new outputs.
- Underflow: on `new_frame && empty`, hold `hphone_l`/`hphone_r`, leave `disp_valid` low and increment `underflow_cnt` (saturates at 255). A push in the same cycle is still written, but it is not bypassed to the output.
- Level update: push only +1; pop only −1; both or neither unchanged.
- Mix arithmetic:
  - Sign-extend each channel to SAMPLE_WIDTH+$clog2(NUM_CH) bits and sum.
  - Arithmetic right shift by $clog2(NUM_CH), which floors toward −∞.
  - Truncate to SAMPLE_WIDTH. Overflow is impossible.
- Attenuation: `>>> atten` on the routed SAMPLE_WIDTH value, which keeps the sign.
- Codec word: `{routed, {(CODEC_WIDTH-SAMPLE_WIDTH){1'b0}}}`.
- `mode` and `atten` are sampled in the pop cycle. Changes between pops do not affect held outputs.
- Reset: FIFO empty, pointers 0, `level` 0, `hphone_l`/`hphone_r`/`disp_sample` 0, `disp_valid` 0, both counters 0. `ready` is 1 out of reset. Reset in mid-operation discards all buffered frames.

## Timing
- Push at cycle t: the frame is visible to a pop from cycle t+1. `level` increments at t+1.
- Pop at cycle t:
  - `hphone_l`, `hphone_r`, `disp_sample` update at t+1.
  - `disp_valid` is high for exactly cycle t+1.
  - `level` decrements at t+1.
- Latency from `new_frame` to the codec words is 1 cycle.
- Counter increments are visible at t+1.
- `ready` is combinational from the full flag and `new_frame`. All other outputs are registered.
- Back-to-back `new_frame` on consecutive cycles is legal; each cycle pops one frame.

## Test plan
- Reset, push frames {ch0=16'h1000, ch1=16'hF000}, mode=1, one `new_frame` -> next cycle `hphone_l`=24'h100000, `hphone_r`=24'hF00000, `disp_sample`=16'h0000, `disp_valid` pulse, `level` 1→0.
- Mode 2 with ch0=16'h0003, ch1=16'h0000 -> both outputs 24'h000100 (3>>>1 = 1). With ch0=16'hFFFF, ch1=0 -> 24'hFFFF00 (floor to −1). Mode 0 with atten=2, ch0=16'h8000 -> 24'hE00000.
- Fill DEPTH=8 frames, push a 9th -> `ready`=0, frame dropped, `overflow_cnt`=1. Then push and pop in the same cycle -> push accepted, `level` stays 8. Drain 8 pops -> frames come out in order.
- `new_frame` on an empty FIFO after one pop of 16'h1234 in mode 0 -> outputs hold 24'h123400, no `disp_valid`, `underflow_cnt`=1. Repeat 300 times -> `underflow_cnt` saturates at 255.
- Push 3 frames, assert `reset` for one cycle mid-stream -> `level`=0, all outputs 0, a subsequent `new_frame` counts one underflow.
- Run DEPTH+3 push/pop cycles -> pointers wrap and data order is preserved. Mode=3 -> outputs 0 while `disp_sample` still reflects the frame.
